wb_trace_buffer: RTL and testbench
==================================

Name: wb_trace_buffer

Overview:
- Sits directly downstream of the CPU top and consumes its commit trace: debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata.
- Captures every qualifying register-file writeback, tags it with a sequence number and buffers it in a FIFO.
- Streams entries out on a valid/ready interface to a trace checker or host link, so a slow consumer never loses ordering and every drop is visible.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- SEQ_W, 16: sequence-number width.
- CAPTURE_R0, 0: 1 = also capture writes to r0; 0 = discard them.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush: empties the FIFO, zeroes counters and flags.
- wb_pc  in  32  debug_wb_pc.
- wb_rf_we  in  4  debug_wb_rf_we.
- wb_rf_wnum  in  5  debug_wb_rf_wnum.
- wb_rf_wdata  in  32  debug_wb_rf_wdata.
- trace_valid  out  1  head entry available.
- trace_ready  in  1  consumer accepts the head entry.
- trace_pc  out  32  head entry PC.
- trace_we  out  4  head entry byte write enables.
- trace_wnum  out  5  head entry destination register.
- trace_wdata  out  32  head entry write data.
- trace_seq  out  SEQ_W  head entry sequence number.
- count  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: at least one event dropped.
- drop_cnt  out  16  dropped events, saturating at 0xFFFF.

Behaviour:
- Reset: reset is asynchronous and active-high; clk is the only clock.
  - While reset is high, all outputs are 0: trace_valid, payload, trace_seq, count, overflow, drop_cnt.
  - FIFO pointers and the sequence counter are 0.
  - Asserting reset mid-stream discards all contents immediately, without waiting for a clock edge.
- Event qualification: event = (|wb_rf_we) && (CAPTURE_R0 || wb_rf_wnum != 0).
  - The trace inputs are sampled at the rising edge.
- Sequence counter (next_seq):
  - Increments by 1, wrapping modulo 2^SEQ_W, on every event, whether the event is accepted or dropped.
  - A gap in trace_seq therefore identifies lost entries.
  - The entry stores the next_seq value from before the increment.
- Pop: pop = trace_valid && trace_ready. The head advances at the edge.
- Push:
  - Accepted when event && (count < DEPTH || pop).
  - Popping while full frees a slot in the same cycle, so push and pop both happen and count is unchanged.
- Drop: event && count == DEPTH && !pop.
  - The entry is discarded.
  - overflow is set to 1 and stays set until reset or clear.
  - drop_cnt increments and saturates at 0xFFFF.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an event accepted at edge N appears on trace_valid after edge N when the FIFO was empty (1 cycle). No bypass from input to output.
- Output payload:
  - Show-ahead: it equals the head entry whenever trace_valid is 1.
  - While trace_valid is 1 and the entry is not yet popped, the payload is held stable.
  - When empty, the payload holds its last value; consumers ignore it.
- Pointers: wrap modulo DEPTH. Full/empty is decided by count, or by an extra pointer wrap bit.
- clear (synchronous) at edge:
  - FIFO empty; next_seq, overflow and drop_cnt set to 0.
  - An event or pop in the same cycle is ignored; the event is not counted.
  - reset has priority over clear.
- Ordering: entries leave in capture order. No reordering and no duplication.

Decomposition:
- Shared package/header trace_pkg holds:
  - field widths: PC_W=32, WE_W=4, WNUM_W=5, DATA_W=32;
  - the packed entry width ENTRY_W = 73 + SEQ_W;
  - field offset constants for packing and unpacking.
- One sub-module, trace_fifo: a generic synchronous FIFO parameterised by width and depth.
  - Interfaces: push/pop/full/empty/count/clear, with show-ahead read data.
- Event qualification, sequencing and drop accounting stay in wb_trace_buffer.

Test Plan:
- Single event, trace_ready=1: pc=0x1C000000, we=0xF, wnum=1, wdata=0x12345678 -> next cycle trace_valid=1 with the same fields and trace_seq=0; popped; count returns to 0.
- Filtering, CAPTURE_R0=0: we=0xF with wnum=0, then we=0x0 with wnum=5 -> no entry and next_seq unchanged; then a valid event -> trace_seq=0.
- Overflow, trace_ready=0, DEPTH=16: 18 consecutive events -> count=16, overflow=1, drop_cnt=2. Drain yields seq 0..15 in order; the next event yields seq 18.
- Full with simultaneous push and pop: FIFO full, trace_ready=1 and an event in the same cycle -> count stays 16, drop_cnt unchanged, new entry appears at the tail.
- Clear mid-stream: 5 entries queued, overflow=1, clear pulsed alongside an event -> count=0, trace_valid=0, overflow=0, drop_cnt=0; the next event yields seq 0.
- Asynchronous reset: reset raised between clock edges with 3 entries queued -> trace_valid, count and overflow go to 0 before the next edge. After reset is released, the first event yields seq 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared widths and field offsets for captured writeback trace entries.
// Latency: none (constants and a width helper only).
// Backpressure: not applicable.
package trace_pkg;

  localparam int PC_W   = 32;
  localparam int WE_W   = 4;
  localparam int WNUM_W = 5;
  localparam int DATA_W = 32;

  // Everything in an entry except the sequence number (73 bits).
  localparam int PAYLOAD_W = PC_W + WE_W + WNUM_W + DATA_W;

  // The sequence number occupies the low SEQ_W bits of an entry. These
  // offsets are measured from just above it.
  localparam int DATA_LSB = 0;
  localparam int WNUM_LSB = DATA_LSB + DATA_W;
  localparam int WE_LSB   = WNUM_LSB + WNUM_W;
  localparam int PC_LSB   = WE_LSB + WE_W;

  // Packed entry width for a given sequence-number width.
  function automatic int entry_w(input int seq_w);
    return PAYLOAD_W + seq_w;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Bundles the commit-trace input and the buffered trace stream output.
// Latency: none (wiring only).
// Backpressure: trace_ready from the consumer throttles the trace stream.
interface wb_trace_buffer_if
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]   wb_pc;
  logic [WE_W-1:0]   wb_rf_we;
  logic [WNUM_W-1:0] wb_rf_wnum;
  logic [DATA_W-1:0] wb_rf_wdata;

  logic              trace_valid;
  logic              trace_ready;
  logic [PC_W-1:0]   trace_pc;
  logic [WE_W-1:0]   trace_we;
  logic [WNUM_W-1:0] trace_wnum;
  logic [DATA_W-1:0] trace_wdata;
  logic [SEQ_W-1:0]  trace_seq;

  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [15:0]       drop_cnt;

  // Producer of the commit trace and consumer of the stream.
  modport master (
    output wb_pc, wb_rf_we, wb_rf_wnum, wb_rf_wdata, trace_ready,
    input  trace_valid, trace_pc, trace_we, trace_wnum, trace_wdata,
    input  trace_seq, count, overflow, drop_cnt
  );

  // The trace buffer itself.
  modport slave (
    input  wb_pc, wb_rf_we, wb_rf_wnum, wb_rf_wdata, trace_ready,
    output trace_valid, trace_pc, trace_we, trace_wnum, trace_wdata,
    output trace_seq, count, overflow, drop_cnt
  );

endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous show-ahead FIFO with synchronous flush.
// Latency: a write is visible on o_rdata after the next edge when empty.
// Backpressure: caller must not push when full unless popping in the same cycle.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_last;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;

  // When empty, keep presenting whatever was shown on the previous cycle.
  assign o_rdata = o_empty ? r_last : r_mem[r_rptr];

  // Storage array: written at the tail, no reset needed.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (i_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Remember the presented word so the output holds once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= '0;
    end else begin
      r_last <= o_rdata;
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures register-file writebacks, tags them with a sequence number, buffers them.
// Latency: one cycle from a captured writeback to trace_valid when empty.
// Backpressure: trace_ready stalls the stream; events arriving while full are dropped and counted.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int SEQ_W      = 16,
  parameter int CAPTURE_R0 = 0
) (
  input logic               clk,
  input logic               reset,
  input logic               clear,
  wb_trace_buffer_if.slave  bus
);

  localparam int ENTRY_W = entry_w(SEQ_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               w_event;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;
  logic [CNT_W-1:0]   w_count;

  logic [SEQ_W-1:0]   r_next_seq;
  logic               r_overflow;
  logic [15:0]        r_drop_cnt;

  // A qualifying writeback: any byte enabled and, unless r0 is traced, a nonzero target.
  assign w_event = (|bus.wb_rf_we) &&
                   ((CAPTURE_R0 != 0) || (bus.wb_rf_wnum != '0));
  assign w_pop   = !w_empty && bus.trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && w_full && !w_pop;

  // Pack the sampled trace fields with the pre-increment sequence number.
  always_comb begin
    w_wr_entry = '0;
    w_wr_entry[SEQ_W-1:0]                 = r_next_seq;
    w_wr_entry[SEQ_W+DATA_LSB +: DATA_W]  = bus.wb_rf_wdata;
    w_wr_entry[SEQ_W+WNUM_LSB +: WNUM_W]  = bus.wb_rf_wnum;
    w_wr_entry[SEQ_W+WE_LSB   +: WE_W]    = bus.wb_rf_we;
    w_wr_entry[SEQ_W+PC_LSB   +: PC_W]    = bus.wb_pc;
  end

  // Sequence numbering advances on every event, kept or dropped, so gaps expose losses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_next_seq <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_next_seq <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_event) begin
        r_next_seq <= r_next_seq + SEQ_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_clear (clear),
    .i_push  (w_push),
    .i_wdata (w_wr_entry),
    .i_pop   (w_pop),
    .o_rdata (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.trace_valid = !w_empty;
  assign bus.trace_seq   = w_rd_entry[SEQ_W-1:0];
  assign bus.trace_wdata = w_rd_entry[SEQ_W+DATA_LSB +: DATA_W];
  assign bus.trace_wnum  = w_rd_entry[SEQ_W+WNUM_LSB +: WNUM_W];
  assign bus.trace_we    = w_rd_entry[SEQ_W+WE_LSB   +: WE_W];
  assign bus.trace_pc    = w_rd_entry[SEQ_W+PC_LSB   +: PC_W];
  assign bus.count       = w_count;
  assign bus.overflow    = r_overflow;
  assign bus.drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed scenarios plus randomized traffic
// against a queue-based model of the capture / drop / sequence rules.
module tb_wb_trace_buffer;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic [15:0] seq;
  } ent_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  wb_trace_buffer_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) bus ();

  wb_trace_buffer #(
    .DEPTH      (DEPTH),
    .SEQ_W      (SEQ_W),
    .CAPTURE_R0 (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t        q[$];
  int unsigned m_seq  = 0;
  bit          m_ovf  = 1'b0;
  int unsigned m_drop = 0;

  always @(posedge clk or posedge reset) begin : model
    bit   ev;
    bit   pop;
    ent_t e;
    if (reset || clear) begin
      q.delete();
      m_seq  = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      ev  = (bus.wb_rf_we != 4'h0) && (bus.wb_rf_wnum != 5'd0);
      pop = (q.size() != 0) && (bus.trace_ready === 1'b1);
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (q.size() < DEPTH) begin
          e.pc    = bus.wb_pc;
          e.we    = bus.wb_rf_we;
          e.wnum  = bus.wb_rf_wnum;
          e.wdata = bus.wb_rf_wdata;
          e.seq   = 16'(m_seq);
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
        m_seq = (m_seq + 1) % 65536;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  ent_t last = '0;

  always @(negedge clk) begin : cmp
    ent_t act;
    ent_t expd;
    act = {bus.trace_pc, bus.trace_we, bus.trace_wnum, bus.trace_wdata, bus.trace_seq};
    if (reset) begin
      check("rst_valid", 96'(bus.trace_valid), 96'd0);
      check("rst_count", 96'(bus.count), 96'd0);
      check("rst_ovf", 96'(bus.overflow), 96'd0);
      check("rst_drop", 96'(bus.drop_cnt), 96'd0);
      check("rst_payload", 96'(act), 96'd0);
      last = '0;
    end else begin
      expd = (q.size() != 0) ? q[0] : last;
      check("valid", 96'(bus.trace_valid), 96'(q.size() != 0));
      check("count", 96'(bus.count), 96'(q.size()));
      check("overflow", 96'(bus.overflow), 96'(m_ovf));
      check("drop_cnt", 96'(bus.drop_cnt), 96'(m_drop));
      check("payload", 96'(act), 96'(expd));
      last = expd;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wnum,
                      input logic [31:0] wd, input bit rdy, input bit clr);
    bus.wb_pc       = pc;
    bus.wb_rf_we    = we;
    bus.wb_rf_wnum  = wnum;
    bus.wb_rf_wdata = wd;
    bus.trace_ready = rdy;
    clear           = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic ev(input bit rdy);
    tick($urandom, 4'($urandom_range(1, 15)), 5'($urandom_range(1, 31)), $urandom, rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    tick($urandom, 4'h0, 5'($urandom_range(0, 31)), $urandom, rdy, 1'b0);
  endtask

  task automatic do_clear();
    tick($urandom, 4'h0, 5'd0, $urandom, 1'b0, 1'b1);
  endtask

  initial begin
    int rdy_pct;
    bus.wb_pc       = '0;
    bus.wb_rf_we    = '0;
    bus.wb_rf_wnum  = '0;
    bus.wb_rf_wdata = '0;
    bus.trace_ready = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check("init_valid", 96'(bus.trace_valid), 96'd0);
    check("init_count", 96'(bus.count), 96'd0);
    reset = 1'b0;

    // Single event with the consumer ready.
    tick(32'h1C00_0000, 4'hF, 5'd1, 32'h1234_5678, 1'b1, 1'b0);
    check("t1_valid", 96'(bus.trace_valid), 96'd1);
    check("t1_pc", 96'(bus.trace_pc), 96'h1C00_0000);
    check("t1_we", 96'(bus.trace_we), 96'hF);
    check("t1_wnum", 96'(bus.trace_wnum), 96'd1);
    check("t1_wdata", 96'(bus.trace_wdata), 96'h1234_5678);
    check("t1_seq", 96'(bus.trace_seq), 96'd0);
    check("t1_count", 96'(bus.count), 96'd1);
    idle(1'b1);
    check("t1_pop_valid", 96'(bus.trace_valid), 96'd0);
    check("t1_pop_count", 96'(bus.count), 96'd0);

    // Filtering of r0 writes and non-writes.
    do_clear();
    tick($urandom, 4'hF, 5'd0, $urandom, 1'b0, 1'b0);
    tick($urandom, 4'h0, 5'd5, $urandom, 1'b0, 1'b0);
    check("t2_count", 96'(bus.count), 96'd0);
    ev(1'b0);
    check("t2_seq", 96'(bus.trace_seq), 96'd0);

    // Overflow while stalled, then ordered drain.
    do_clear();
    repeat (18) ev(1'b0);
    check("t3_count", 96'(bus.count), 96'd16);
    check("t3_ovf", 96'(bus.overflow), 96'd1);
    check("t3_drop", 96'(bus.drop_cnt), 96'd2);
    for (int i = 0; i < 16; i++) begin
      check("t3_drain_seq", 96'(bus.trace_seq), 96'(i));
      idle(1'b1);
    end
    check("t3_drained", 96'(bus.count), 96'd0);
    ev(1'b0);
    check("t3_next_seq", 96'(bus.trace_seq), 96'd18);

    // Full FIFO with push and pop in the same cycle.
    repeat (15) ev(1'b0);
    check("t4_full", 96'(bus.count), 96'd16);
    ev(1'b1);
    check("t4_count", 96'(bus.count), 96'd16);
    check("t4_drop", 96'(bus.drop_cnt), 96'd2);
    check("t4_head", 96'(bus.trace_seq), 96'd19);

    // Clear alongside an event.
    do_clear();
    repeat (17) ev(1'b0);
    repeat (11) idle(1'b1);
    check("t5_count", 96'(bus.count), 96'd5);
    check("t5_ovf", 96'(bus.overflow), 96'd1);
    tick($urandom, 4'hF, 5'd3, $urandom, 1'b1, 1'b1);
    check("t5_clr_count", 96'(bus.count), 96'd0);
    check("t5_clr_valid", 96'(bus.trace_valid), 96'd0);
    check("t5_clr_ovf", 96'(bus.overflow), 96'd0);
    check("t5_clr_drop", 96'(bus.drop_cnt), 96'd0);
    ev(1'b0);
    check("t5_seq", 96'(bus.trace_seq), 96'd0);

    // Asynchronous reset between edges.
    repeat (17) ev(1'b0);
    repeat (13) idle(1'b1);
    check("t6_count", 96'(bus.count), 96'd3);
    check("t6_ovf", 96'(bus.overflow), 96'd1);
    #1;
    reset = 1'b1;
    bus.wb_rf_we    = 4'h0;
    bus.trace_ready = 1'b0;
    #1;
    check("t6_rst_valid", 96'(bus.trace_valid), 96'd0);
    check("t6_rst_count", 96'(bus.count), 96'd0);
    check("t6_rst_ovf", 96'(bus.overflow), 96'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #2;
    ev(1'b0);
    check("t6_seq", 96'(bus.trace_seq), 96'd0);

    // Randomized traffic with shifting consumer speed.
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rdy_pct = $urandom_range(5, 95);
      tick($urandom,
           ($urandom_range(0, 99) < 25) ? 4'h0 : 4'($urandom),
           ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom),
           $urandom,
           $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 199) == 0);
    end
    repeat (40) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
